sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Copies one rectangular sprite tile from the sprite sheet ROM into the 640x480 frame buffer.
- Each copy is a write burst, so the VGA-side reader can scan the frame buffer without per-pixel sprite math.
- Sits between the game-logic FSM (which issues start requests) and the frame-buffer write port.
- Chroma-key pixels (transparent green) are skipped. Off-screen pixels are clipped.

Parameters:
- SHEET_W, 38: sprite sheet row pitch in pixels (ROM address stride per row).
- BLIT_W, 20: tile width in pixels (>=1).
- BLIT_H, 16: tile height in pixels (>=1).
- FB_W, 640: frame buffer width / row pitch.
- FB_H, 480: frame buffer height.
- KEY_COLOR, 24'h00ff00: transparent colour; never written.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- src_base  in  19  ROM address of tile top-left pixel
- dst_x  in  10  frame-buffer x of tile top-left
- dst_y  in  10  frame-buffer y of tile top-left
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle pulse when a blit completes
- rom_addr  out  19  sprite ROM read address (synchronous ROM, 1-cycle latency)
- rom_data  in  24  sprite ROM data for the address presented the previous cycle
- fb_addr  out  19  frame-buffer write address
- fb_data  out  24  frame-buffer write colour
- fb_we  out  1  write request
- fb_ready  in  1  frame buffer accepts the write this cycle

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0; row/column counters cleared.
- Reset mid-blit aborts immediately. fb_we drops in the same instant; no done pulse is generated.
- States and transitions:
  - IDLE: start=1 latches src_base, dst_x, dst_y; r=0, c=0; go to ADDR.
  - ADDR: drive rom_addr = src_base + r*SHEET_W + c (19-bit, wraps modulo 2^19); go to DATA.
  - DATA: rom_data is valid.
    - If rom_data==KEY_COLOR, or (dst_x+c)>=FB_W, or (dst_y+r)>=FB_H: skip, advance.
    - Otherwise register fb_addr = (dst_y+r)*FB_W + (dst_x+c), fb_data = rom_data, fb_we=1; go to WRITE.
    - The clip sums are computed in 11 bits so no wrap occurs.
  - WRITE: hold fb_we, fb_addr and fb_data stable until fb_ready=1. The write completes on that cycle; fb_we=0 next cycle; advance.
  - advance:
    - If c<BLIT_W-1: c++, go to ADDR.
    - Else if r<BLIT_H-1: c=0, r++, go to ADDR.
    - Else go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- busy is 1 in ADDR, DATA and WRITE; 0 in IDLE and DONE.
- busy rises the cycle after start is sampled.
- start while busy or in DONE is ignored (not queued). Input changes after start is sampled have no effect.
- Timing per pixel: skipped/clipped = 2 cycles; written = 2 + N cycles, where N>=1 is the number of WRITE cycles up to and including the one with fb_ready=1.
- Pixels are processed row-major, left to right, top to bottom. At most one fb write is outstanding at a time.
- fb_we is never asserted outside WRITE.
- fb_ready outside WRITE is ignored.

Optional Feature:
- Macro: SPRITE_BLITTER_MIRROR_EN.
- When defined:
  - Adds input port flip_x (1 bit), latched with start.
  - If latched flip_x=1, the source column is BLIT_W-1-c, so rom_addr = src_base + r*SHEET_W + (BLIT_W-1-c).
  - Destination column remains dst_x+c, producing a horizontally mirrored tile (duck facing left).
- When undefined: port absent; behaviour as if flip_x=0. Gate count and timing are unchanged versus the base design.

Test Plan:
- Opaque tile:
  - Stimulus: all-opaque ROM (0x123456), dst=(100,50), src_base=0, fb_ready tied 1, start pulse.
  - Required: 320 writes in row-major order; first fb_addr=50*640+100=32100, last=65*640+119=41719.
  - Required: busy high exactly 960 cycles, then done=1 for 1 cycle.
- Chroma key:
  - Stimulus: ROM where every even column = 24'h00ff00.
  - Required: exactly 160 writes, all odd columns; no write ever carries 24'h00ff00.
  - Required: busy lasts 160*3 + 160*2 = 800 cycles.
- Clipping:
  - Stimulus: dst=(630,470), opaque ROM.
  - Required: only the 10x10 in-screen pixels are written (100 writes); max fb_addr=479*640+639=307199; no address >=307200.
- Backpressure:
  - Stimulus: fb_ready held 0 for 5 cycles on the first write.
  - Required: fb_we, fb_addr and fb_data stay stable for those 5 cycles plus the accepting cycle; no duplicate write.
  - Required: start pulses during busy are ignored, giving exactly one done pulse.
- Reset abort:
  - Stimulus: Reset_n driven low mid-WRITE.
  - Required: fb_we, busy and done are 0 immediately.
  - Required: after release, a new start begins at r=0, c=0 (first rom_addr=src_base).
- Mirror (SPRITE_BLITTER_MIRROR_EN, flip_x=1):
  - Stimulus: src_base=550, mirrored blit.
  - Required: first rom_addr=569; the write to dst column 0 carries the ROM pixel from column 19.

Source files
------------

// File: rtl/sprite_blitter.sv
// Copies one BLIT_W x BLIT_H sprite tile from a synchronous ROM into the frame buffer,
// skipping KEY_COLOR pixels and clipping off-screen ones. Define SPRITE_BLITTER_MIRROR_EN for flip_x.
module sprite_blitter #(
  parameter int          SHEET_W   = 38,
  parameter int          BLIT_W    = 20,
  parameter int          BLIT_H    = 16,
  parameter int          FB_W      = 640,
  parameter int          FB_H      = 480,
  parameter logic [23:0] KEY_COLOR = 24'h00ff00
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [18:0] src_base,
  input  logic [9:0]  dst_x,
  input  logic [9:0]  dst_y,
`ifdef SPRITE_BLITTER_MIRROR_EN
  input  logic        flip_x,
`endif
  output logic        busy,
  output logic        done,
  output logic [18:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data,
  output logic        fb_we,
  input  logic        fb_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [9:0] LAST_COL = 10'(BLIT_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(BLIT_H - 1);

  state_t      state_r, state_s, adv_state_s;
  logic [18:0] base_r, base_s;
  logic [9:0]  dx_r, dx_s, dy_r, dy_s;
  logic [9:0]  row_r, row_s, col_r, col_s;
  logic [9:0]  adv_row_s, adv_col_s;
  logic        flip_s;
  logic        write_s;
  logic [10:0] x_sum_s, y_sum_s;
  logic        visible_s;
  logic [18:0] rom_addr_s, fb_addr_s;
  logic        busy_r, done_r, fb_we_r;
  logic [18:0] rom_addr_r, fb_addr_r;
  logic [23:0] fb_data_r;

  // Source address wraps modulo 2^19; a mirrored fetch reads the tile right to left.
  function automatic logic [18:0] src_addr(input logic [18:0] base, input logic [9:0] row,
                                           input logic [9:0] col, input logic flip);
    logic [9:0] scol;
    scol = flip ? (LAST_COL - col) : col;
    return base + 19'(row) * 19'(SHEET_W) + 19'(scol);
  endfunction

`ifdef SPRITE_BLITTER_MIRROR_EN
  logic flip_r;
  assign flip_s = (state_r == S_IDLE && start) ? flip_x : flip_r;

  // Latch the mirror request together with the other start arguments.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) flip_r <= 1'b0;
    else          flip_r <= flip_s;
  end
`else
  assign flip_s = 1'b0;
`endif

  assign x_sum_s    = {1'b0, dx_r} + {1'b0, col_r};
  assign y_sum_s    = {1'b0, dy_r} + {1'b0, row_r};
  assign visible_s  = (x_sum_s < 11'(FB_W)) && (y_sum_s < 11'(FB_H));
  assign fb_addr_s  = 19'(y_sum_s) * 19'(FB_W) + 19'(x_sum_s);
  assign rom_addr_s = src_addr(base_s, row_s, col_s, flip_s);

  // Row-major step to the next pixel, or finish after the bottom-right one.
  always_comb begin
    adv_row_s   = row_r;
    adv_col_s   = col_r;
    adv_state_s = S_ADDR;
    if (col_r != LAST_COL) begin
      adv_col_s = col_r + 10'd1;
    end else if (row_r != LAST_ROW) begin
      adv_col_s = 10'd0;
      adv_row_s = row_r + 10'd1;
    end else begin
      adv_state_s = S_DONE;
    end
  end

  // Next-state logic for the blit sequencer.
  always_comb begin
    state_s = state_r;
    base_s  = base_r;
    dx_s    = dx_r;
    dy_s    = dy_r;
    row_s   = row_r;
    col_s   = col_r;
    write_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          base_s  = src_base;
          dx_s    = dst_x;
          dy_s    = dst_y;
          row_s   = 10'd0;
          col_s   = 10'd0;
          state_s = S_ADDR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ADDR: state_s = S_DATA;
      S_DATA: begin
        if (rom_data == KEY_COLOR || !visible_s) begin
          row_s   = adv_row_s;
          col_s   = adv_col_s;
          state_s = adv_state_s;
        end else begin
          write_s = 1'b1;
          state_s = S_WRITE;
        end
      end
      S_WRITE: begin
        if (fb_ready) begin
          row_s   = adv_row_s;
          col_s   = adv_col_s;
          state_s = adv_state_s;
        end else begin
          state_s = S_WRITE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, latched arguments and registered outputs, all derived from the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= S_IDLE;
      base_r     <= 19'd0;
      dx_r       <= 10'd0;
      dy_r       <= 10'd0;
      row_r      <= 10'd0;
      col_r      <= 10'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fb_we_r    <= 1'b0;
      rom_addr_r <= 19'd0;
      fb_addr_r  <= 19'd0;
      fb_data_r  <= 24'd0;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      dx_r    <= dx_s;
      dy_r    <= dy_s;
      row_r   <= row_s;
      col_r   <= col_s;
      busy_r  <= (state_s == S_ADDR) || (state_s == S_DATA) || (state_s == S_WRITE);
      done_r  <= (state_s == S_DONE);
      fb_we_r <= (state_s == S_WRITE);
      if (state_s == S_ADDR) rom_addr_r <= rom_addr_s;
      if (write_s) begin
        fb_addr_r <= fb_addr_s;
        fb_data_r <= rom_data;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign fb_we    = fb_we_r;
  assign rom_addr = rom_addr_r;
  assign fb_addr  = fb_addr_r;
  assign fb_data  = fb_data_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized self-checking bench for sprite_blitter against a per-pixel reference list.
// Mirror checks are included when SPRITE_BLITTER_MIRROR_EN is defined.
module tb_sprite_blitter;
  localparam int          W   = 20;
  localparam int          H   = 16;
  localparam logic [23:0] KEY = 24'h00ff00;

  logic        Clk = 1'b0, Reset_n = 1'b0, start = 1'b0;
  logic [18:0] src_base = 19'd0;
  logic [9:0]  dst_x = 10'd0, dst_y = 10'd0;
  logic        flip_x = 1'b0;
  logic        busy, done, fb_we;
  logic [18:0] rom_addr, fb_addr;
  logic [23:0] rom_data = 24'd0, fb_data;
  logic        fb_ready = 1'b0;

  int          total = 0, bad = 0;
  int          mode = 0;
  logic [31:0] seed = 32'd0;
  logic [18:0] exp_a[$];
  logic [23:0] exp_d[$];

  sprite_blitter dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .src_base(src_base),
    .dst_x(dst_x), .dst_y(dst_y),
`ifdef SPRITE_BLITTER_MIRROR_EN
    .flip_x(flip_x),
`endif
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #10 Clk = ~Clk;

  // Sprite sheet contents as a function of address; the pattern is chosen per test.
  function automatic logic [23:0] rom_pix(input logic [18:0] a);
    logic [31:0] h;
    logic [18:0] m;
    logic [23:0] p;
    case (mode)
      0: p = 24'h123456;
      1: begin
        m = a % 19'd38;
        p = (m[0] == 1'b0) ? KEY : (24'h400000 | {5'd0, a});
      end
      2: begin
        h = ({13'd0, a} * 32'h9E3779B1) ^ seed;
        if (h[3:0] == 4'd0) p = KEY;
        else begin
          p = h[31:8];
          if (p == KEY) p = p ^ 24'h000001;
        end
      end
      default: p = 24'h800000 | {5'd0, a};
    endcase
    return p;
  endfunction

  always @(posedge Clk) rom_data <= rom_pix(rom_addr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_blit(input logic [18:0] base, input logic [9:0] dx, input logic [9:0] dy,
                          input logic flip, input int first_wait, input int max_wait, input bit spam,
                          output int nwr, output int busy_cnt, output logic [18:0] first_fa,
                          output logic [18:0] last_fa, output logic [23:0] first_fd,
                          output logic [18:0] first_ra);
    logic        fe;
    logic [18:0] sa, exp_ra, hold_a, ea;
    logic [23:0] pix, hold_d, ed;
    int          xs, ys, sc, exp_busy, done_cnt, k, post;
    bit          pending, seen;
`ifdef SPRITE_BLITTER_MIRROR_EN
    fe = flip;
`else
    fe = 1'b0;
`endif
    exp_a.delete();
    exp_d.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        sc  = fe ? (W - 1 - c) : c;
        sa  = base + 19'(r * 38 + sc);
        pix = rom_pix(sa);
        xs  = int'(dx) + c;
        ys  = int'(dy) + r;
        if (pix != KEY && xs < 640 && ys < 480) begin
          exp_a.push_back(19'(ys * 640 + xs));
          exp_d.push_back(pix);
        end
      end
    end
    exp_ra   = base + 19'(fe ? (W - 1) : 0);
    exp_busy = 2 * W * H;
    nwr = 0; busy_cnt = 0; done_cnt = 0; k = 0; post = 0;
    pending = 0; seen = 0;
    first_fa = 19'd0; last_fa = 19'd0; first_fd = 24'd0; first_ra = 19'd0;
    hold_a = 19'd0; hold_d = 24'd0;

    @(negedge Clk);
    src_base = base; dst_x = dx; dst_y = dy; flip_x = flip; start = 1'b1; fb_ready = 1'b0;
    @(negedge Clk);
    start = 1'b0;
    src_base = 19'($urandom); dst_x = 10'($urandom); dst_y = 10'($urandom);
    flip_x = 1'($urandom_range(1, 0));
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (busy) begin
        busy_cnt++;
        if (!seen) begin seen = 1; first_ra = rom_addr; end
      end
      if (done) begin
        done_cnt++;
        check_val("done_while_busy", busy, 0);
      end
      if (fb_we && !pending) begin
        if (exp_a.size() == 0) check_val("extra_write", 1, 0);
        else begin
          ea = exp_a.pop_front();
          ed = exp_d.pop_front();
          check_val("fb_addr", fb_addr, ea);
          check_val("fb_data", fb_data, ed);
        end
        if (nwr == 0) begin first_fa = fb_addr; first_fd = fb_data; end
        last_fa = fb_addr; hold_a = fb_addr; hold_d = fb_data;
        nwr++;
        k = (nwr == 1) ? first_wait : $urandom_range(max_wait, 0);
        exp_busy += k + 1;
        pending = 1;
        fb_ready = (k == 0);
      end else if (fb_we && pending) begin
        check_val("hold_addr", fb_addr, hold_a);
        check_val("hold_data", fb_data, hold_d);
        if (k == 0) check_val("we_after_accept", fb_we, 0);
        else k--;
        fb_ready = (k == 0);
      end else begin
        if (pending) begin
          check_val("early_drop", k, 0);
          pending = 0;
        end
        fb_ready = 1'($urandom_range(1, 0));
      end
      start = (spam && busy) ? 1'($urandom_range(1, 0)) : 1'b0;
      if (done_cnt > 0) begin
        post++;
        if (post > 3) break;
      end
      @(negedge Clk);
    end
    start = 1'b0;
    fb_ready = 1'b0;
    check_val("timeout", (done_cnt > 0), 1);
    check_val("done_pulses", done_cnt, 1);
    check_val("missing_writes", exp_a.size(), 0);
    check_val("busy_cycles", busy_cnt, exp_busy);
    check_val("first_rom_addr", first_ra, exp_ra);
  endtask

  initial begin
    int          nwr, bc;
    logic [18:0] ffa, lfa, fra;
    logic [23:0] ffd;

    #5;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_fb_we", fb_we, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_fb_addr", fb_addr, 0);
    check_val("rst_fb_data", fb_data, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    mode = 0;
    run_blit(19'd0, 10'd100, 10'd50, 1'b0, 0, 0, 1'b0, nwr, bc, ffa, lfa, ffd, fra);
    check_val("opaque_writes", nwr, 320);
    check_val("opaque_first", ffa, 32100);
    check_val("opaque_last", lfa, 41719);
    check_val("opaque_busy", bc, 960);
    check_val("opaque_data", ffd, 24'h123456);

    mode = 1;
    run_blit(19'd0, 10'd10, 10'd10, 1'b0, 0, 0, 1'b0, nwr, bc, ffa, lfa, ffd, fra);
    check_val("chroma_writes", nwr, 160);
    check_val("chroma_busy", bc, 800);
    check_val("chroma_first", ffa, 10 * 640 + 11);

    mode = 0;
    run_blit(19'd0, 10'd630, 10'd470, 1'b0, 0, 0, 1'b0, nwr, bc, ffa, lfa, ffd, fra);
    check_val("clip_writes", nwr, 100);
    check_val("clip_last", lfa, 307199);
    check_val("clip_busy", bc, 740);

    mode = 2; seed = 32'h5a5a1234;
    run_blit(19'd1000, 10'd200, 10'd100, 1'b0, 5, 2, 1'b1, nwr, bc, ffa, lfa, ffd, fra);

    mode = 0; fb_ready = 1'b0;
    @(negedge Clk);
    src_base = 19'd1234; dst_x = 10'd0; dst_y = 10'd0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !fb_we; i++) @(negedge Clk);
    check_val("abort_in_write", fb_we, 1);
    Reset_n = 1'b0;
    #1;
    check_val("abort_fb_we", fb_we, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    repeat (2) @(negedge Clk);
    check_val("abort_no_done", done, 0);
    Reset_n = 1'b1;
    run_blit(19'd777, 10'd5, 10'd5, 1'b0, 0, 1, 1'b0, nwr, bc, ffa, lfa, ffd, fra);
    check_val("restart_rom_addr", fra, 777);

`ifdef SPRITE_BLITTER_MIRROR_EN
    mode = 3;
    run_blit(19'd550, 10'd0, 10'd0, 1'b1, 0, 1, 1'b0, nwr, bc, ffa, lfa, ffd, fra);
    check_val("mirror_rom_addr", fra, 569);
    check_val("mirror_col0_data", ffd, 24'h800000 | 24'd569);
    check_val("mirror_col0_addr", ffa, 0);
`endif

    for (int t = 0; t < 6; t++) begin
      mode = 2;
      seed = $urandom;
      run_blit(19'($urandom), 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)),
               1'($urandom_range(1, 0)), $urandom_range(3, 0), 3, 1'b1,
               nwr, bc, ffa, lfa, ffd, fra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
